mb_sequencer: RTL and testbench

Math Box sequencer: control end of the Math Box program counter. Accepts a CPU command write, resolves the command to a microcode start address through the A1 start-address ROM, and drives the counter's load address and active-low load/enable (PCEN) so the program counter loads and then runs. Monitors the microcode STOP bit, reports BUSY/DONE status to the CPU side, and optionally aborts runaway programs. Sits between the CPU write decode and the program counter / A1 ROM.

---
 rtl/mb_pkg.sv | 24 ++
 rtl/mb_step_watchdog.sv | 42 ++++
 rtl/mb_sequencer.sv | 140 ++++++++++++++
 tb/tb_mb_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mb_pkg.sv
// Shared types and constants for the Math Box sequencer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mb_pkg;

  localparam int MB_CMD_W      = 5;
  localparam int MB_ADDR_W     = 8;
  localparam int MB_STEP_W     = 8;
  localparam int MB_WDOG_LIMIT = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_LOAD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_FINISH = 3'd4
  } mb_seq_state_t;

  // BUSY covers everything from command acceptance through the last RUN cycle.
  function automatic logic mb_is_busy_state(input mb_seq_state_t s);
    return (s == ST_LOOKUP) || (s == ST_LOAD) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/mb_step_watchdog.sv
// Step counter for RUN: cleared in LOAD, incremented each RUN cycle, flags the limit.
// Latency: limit_hit is combinational in the RUN cycle whose increment reaches LIMIT.
// Backpressure: none; counts every cycle inc is high.
module mb_step_watchdog
  import mb_pkg::*;
#(
  parameter int unsigned LIMIT = MB_WDOG_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic limit_hit
);

  logic [MB_STEP_W-1:0] cnt_q, cnt_d;
  logic [MB_STEP_W:0]   cnt_next;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Compare the post-increment value so LIMIT RUN cycles elapse before the hit.
  assign cnt_next  = {1'b0, cnt_q} + 1'b1;
  assign limit_hit = inc && (cnt_next == LIMIT[MB_STEP_W:0]);

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mb_sequencer.sv
// Math Box sequencer: CPU command -> A1 start address -> PC load, then run until STOP.
// Latency: write-to-DONE is N+3 cycles for an N-word program (4 for a single word).
// Backpressure: none; writes while busy (incl. FINISH) are dropped and set OVERRUN.
// Optional runaway abort is built when MB_WATCHDOG_EN is defined.
module mb_sequencer
  import mb_pkg::*;
#(
  parameter int unsigned WDOG_LIMIT = MB_WDOG_LIMIT
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CPU_WR,
  input  logic [MB_CMD_W-1:0]  CPU_ADDR,
  output logic [MB_CMD_W-1:0]  CMD_ADDR,
  input  logic [MB_ADDR_W-1:0] START_ADDR,
  input  logic                 STOP,
  output logic [MB_ADDR_W-1:0] ADDR_OUT,
  output logic                 PCEN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 OVERRUN,
  output logic                 TIMEOUT
);

  mb_seq_state_t state_q, state_d;

  logic [MB_CMD_W-1:0]  cmd_addr_q, cmd_addr_d;
  logic [MB_ADDR_W-1:0] addr_out_q, addr_out_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic                 accept;
  logic                 wdog_hit;

  assign accept = (state_q == ST_IDLE) && CPU_WR;

`ifdef MB_WATCHDOG_EN
  logic timeout_q, timeout_d;

  mb_step_watchdog #(
    .LIMIT (WDOG_LIMIT)
  ) u_step_watchdog (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .clr       (state_q == ST_LOAD),
    .inc       (state_q == ST_RUN),
    .limit_hit (wdog_hit)
  );

  // TIMEOUT: cleared by an accepted write, set only when the limit wins over STOP.
  always_comb begin
    timeout_d = timeout_q;
    if (accept) begin
      timeout_d = 1'b0;
    end else if ((state_q == ST_RUN) && wdog_hit && !STOP) begin
      timeout_d = 1'b1;
    end
  end

  // TIMEOUT register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign wdog_hit = 1'b0;
  assign TIMEOUT  = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; RUN exits on STOP or, when built in, the step limit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (CPU_WR) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_RUN;
      ST_RUN:    if (STOP || wdog_hit) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode: PCEN and DONE come straight off the state register.
  always_comb begin
    PCEN = (state_q == ST_RUN);
    DONE = (state_q == ST_FINISH);
  end

  // Next values for the registered outputs.
  always_comb begin
    cmd_addr_d = cmd_addr_q;
    addr_out_d = addr_out_q;
    overrun_d  = overrun_q;
    busy_d     = mb_is_busy_state(state_d);
    if (accept) begin
      cmd_addr_d = CPU_ADDR;
      overrun_d  = 1'b0;
    end else if (CPU_WR) begin
      overrun_d  = 1'b1;
    end
    // START_ADDR settles during LOOKUP, one cycle after CMD_ADDR was registered.
    if (state_q == ST_LOOKUP) begin
      addr_out_d = START_ADDR;
    end
  end

  // Registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cmd_addr_q <= '0;
      addr_out_q <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      cmd_addr_q <= cmd_addr_d;
      addr_out_q <= addr_out_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign CMD_ADDR = cmd_addr_q;
  assign ADDR_OUT = addr_out_q;
  assign BUSY     = busy_q;
  assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_mb_sequencer.sv
// Directed bench for mb_sequencer with a behavioural program counter and A1 ROM.
// Build with MB_WATCHDOG_EN defined to cover the abort path (WDOG_LIMIT = 8).
module tb_mb_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_wr;
  logic [4:0] cpu_addr;
  logic [4:0] cmd_addr;
  logic [7:0] start_addr;
  logic       stop;
  logic [7:0] addr_out;
  logic       pcen, busy, done, overrun, timeout;

  logic [7:0] rom [32];
  logic [7:0] pc;
  logic       stop_en;
  logic [7:0] stop_word;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign start_addr = rom[cmd_addr];
  assign stop       = stop_en && (pc == stop_word);

  // Program counter model: load when PCEN is low, increment when high.
  always @(posedge clk) begin
    if (!rst_n) pc <= 8'h00;
    else if (pcen) pc <= pc + 8'd1;
    else pc <= addr_out;
  end

  mb_sequencer #(.WDOG_LIMIT(8)) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .CPU_WR     (cpu_wr),
    .CPU_ADDR   (cpu_addr),
    .CMD_ADDR   (cmd_addr),
    .START_ADDR (start_addr),
    .STOP       (stop),
    .ADDR_OUT   (addr_out),
    .PCEN       (pcen),
    .BUSY       (busy),
    .DONE       (done),
    .OVERRUN    (overrun),
    .TIMEOUT    (timeout)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1 time unit after an edge; returns 1 time unit after the sampling edge E0.
  task automatic do_write(input logic [4:0] a);
    cpu_addr = a;
    cpu_wr   = 1'b1;
    step(1);
    cpu_wr   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(2);
    checks++; if (cmd_addr !== 5'h00) begin failures++; $display("FAIL reset_cmd_addr got=%h exp=00", cmd_addr); end
    checks++; if (addr_out !== 8'h00) begin failures++; $display("FAIL reset_addr_out got=%h exp=00", addr_out); end
    checks++; if (pcen !== 1'b0) begin failures++; $display("FAIL reset_pcen got=%b exp=0", pcen); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    rst_n = 1'b1;
    step(1);
  endtask

  // Three-word program 0x40..0x42; index k means "just after edge Ek".
  task automatic test_basic;
    logic [6:0] exp_pcen, exp_done, exp_busy;
    exp_pcen = 7'b0011100;
    exp_done = 7'b0100000;
    exp_busy = 7'b0011111;
    rom[3]    = 8'h40;
    stop_en   = 1'b1;
    stop_word = 8'h42;
    do_write(5'h03);
    checks++; if (cmd_addr !== 5'h03) begin failures++; $display("FAIL basic_cmd_addr got=%h exp=03", cmd_addr); end
    for (int k = 0; k < 7; k++) begin
      if (k > 0) step(1);
      if (k == 1) begin
        checks++; if (addr_out !== 8'h40) begin failures++; $display("FAIL basic_addr_out got=%h exp=40", addr_out); end
      end
      checks++; if (pcen !== exp_pcen[k]) begin failures++; $display("FAIL basic_pcen k=%0d got=%b exp=%b", k, pcen, exp_pcen[k]); end
      checks++; if (done !== exp_done[k]) begin failures++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, done, exp_done[k]); end
      checks++; if (busy !== exp_busy[k]) begin failures++; $display("FAIL basic_busy k=%0d got=%b exp=%b", k, busy, exp_busy[k]); end
    end
  endtask

  // Start word carries STOP; a write landing in FINISH is dropped and flagged.
  task automatic test_single_word;
    logic [4:0] exp_pcen, exp_done, exp_busy;
    exp_pcen = 5'b00100;
    exp_done = 5'b01000;
    exp_busy = 5'b00111;
    rom[5]    = 8'h10;
    stop_en   = 1'b1;
    stop_word = 8'h10;
    do_write(5'h05);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step(1);
      if (k == 4) cpu_wr = 1'b0;
      checks++; if (pcen !== exp_pcen[k]) begin failures++; $display("FAIL single_pcen k=%0d got=%b exp=%b", k, pcen, exp_pcen[k]); end
      checks++; if (done !== exp_done[k]) begin failures++; $display("FAIL single_done k=%0d got=%b exp=%b", k, done, exp_done[k]); end
      checks++; if (busy !== exp_busy[k]) begin failures++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, exp_busy[k]); end
      if (k == 3) begin
        cpu_addr = 5'h09;
        cpu_wr   = 1'b1;
      end
    end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL finish_wr_overrun got=%b exp=1", overrun); end
    checks++; if (cmd_addr !== 5'h05) begin failures++; $display("FAIL finish_wr_cmd_addr got=%h exp=05", cmd_addr); end
    step(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL finish_wr_not_accepted busy=%b exp=0", busy); end
  endtask

  // Write during RUN is ignored; the next accepted write clears OVERRUN.
  task automatic test_overrun;
    int n;
    rom[7]    = 8'h20;
    stop_en   = 1'b1;
    stop_word = 8'h24;
    do_write(5'h07);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_cleared_on_accept got=%b exp=0", overrun); end
    step(3);
    cpu_addr = 5'h03;
    cpu_wr   = 1'b1;
    step(1);
    cpu_wr   = 1'b0;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    checks++; if (cmd_addr !== 5'h07) begin failures++; $display("FAIL overrun_cmd_kept got=%h exp=07", cmd_addr); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL overrun_busy got=%b exp=1", busy); end
    n = 4;
    while (done !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    checks++; if (n != 7) begin failures++; $display("FAIL overrun_done_edge got=%0d exp=7", n); end
    step(1);
  endtask

  // Reset pulse while the program is running returns everything to idle.
  task automatic test_reset_mid_run;
    rom[2]  = 8'h55;
    stop_en = 1'b0;
    do_write(5'h02);
    step(3);
    cpu_wr = 1'b1;
    step(1);
    cpu_wr = 1'b0;
    checks++; if (pcen !== 1'b1 || overrun !== 1'b1) begin failures++; $display("FAIL midrun_pre pcen=%b overrun=%b exp=1 1", pcen, overrun); end
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    checks++; if (pcen !== 1'b0) begin failures++; $display("FAIL midrun_pcen got=%b exp=0", pcen); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrun_busy got=%b exp=0", busy); end
    checks++; if (addr_out !== 8'h00) begin failures++; $display("FAIL midrun_addr_out got=%h exp=00", addr_out); end
    checks++; if (cmd_addr !== 5'h00) begin failures++; $display("FAIL midrun_cmd_addr got=%h exp=00", cmd_addr); end
    checks++; if (overrun !== 1'b0 || timeout !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrun_flags ovr=%b to=%b done=%b exp=0 0 0", overrun, timeout, done); end
    step(1);
    checks++; if (busy !== 1'b0 || pcen !== 1'b0) begin failures++; $display("FAIL midrun_stays_idle busy=%b pcen=%b exp=0 0", busy, pcen); end
  endtask

`ifdef MB_WATCHDOG_EN
  // STOP never arrives: abort after 8 RUN cycles, DONE just after E10.
  task automatic test_watchdog;
    int n;
    rom[9]  = 8'h80;
    stop_en = 1'b0;
    do_write(5'h09);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    checks++; if (n != 10) begin failures++; $display("FAIL wdog_done_edge got=%0d exp=10", n); end
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL wdog_timeout got=%b exp=1", timeout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wdog_busy got=%b exp=0", busy); end
    step(1);
    checks++; if (timeout !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL wdog_sticky to=%b done=%b exp=1 0", timeout, done); end
  endtask

  // STOP on the limit cycle itself takes priority: no TIMEOUT.
  task automatic test_wdog_stop_at_limit;
    int n;
    stop_en   = 1'b1;
    stop_word = 8'h87;
    do_write(5'h09);
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL wdog_cleared_on_accept got=%b exp=0", timeout); end
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    checks++; if (n != 10) begin failures++; $display("FAIL wdog_limit_done_edge got=%0d exp=10", n); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL wdog_limit_timeout got=%b exp=0", timeout); end
    step(1);
  endtask
`else
  // Without the watchdog, a program lacking STOP keeps running.
  task automatic test_no_watchdog;
    int n;
    rom[9]  = 8'h80;
    stop_en = 1'b0;
    do_write(5'h09);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    checks++; if (n != 40) begin failures++; $display("FAIL nowdog_unexpected_done edge=%0d exp=none", n); end
    checks++; if (busy !== 1'b1 || pcen !== 1'b1) begin failures++; $display("FAIL nowdog_running busy=%b pcen=%b exp=1 1", busy, pcen); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL nowdog_timeout got=%b exp=0", timeout); end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    cpu_wr    = 1'b0;
    cpu_addr  = 5'h00;
    stop_en   = 1'b0;
    stop_word = 8'h00;
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    #1;
    test_reset;
    test_basic;
    test_single_word;
    test_overrun;
    test_reset_mid_run;
`ifdef MB_WATCHDOG_EN
    test_watchdog;
    test_wdog_stop_at_limit;
`else
    test_no_watchdog;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
